// File: rtl/lpf_decimator.sv
// rtl/lpf_decimator.sv - fill-discard, decimate, round/shift/saturate, FWFT output FIFO
module lpf_decimator #(
    parameter int DECIM = 8,
    parameter int SHIFT = 12,
    parameter int FILL  = 31,
    parameter int DEPTH = 8
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        in_en,
    input  logic [31:0] in_real,
    input  logic [31:0] in_imag,
    output logic [15:0] out_real,
    output logic [15:0] out_imag,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        fill_done,
    output logic        overflow
);

    localparam int FW = (FILL > 1) ? $clog2(FILL) : 1;
    localparam int DW = $clog2(DECIM);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic signed [32:0] RND = 33'sd1 <<< (SHIFT - 1);

    typedef enum logic {S_FILL, S_RUN} state_t;

    state_t        state_q;
    logic [FW-1:0] fill_cnt_q;
    logic [DW-1:0] dec_cnt_q;
    logic          fill_done_q;

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= S_FILL;
            fill_cnt_q  <= '0;
            dec_cnt_q   <= '0;
            fill_done_q <= 1'b0;
        end else if (in_en) begin
            case (state_q)
                S_FILL: begin
                    if (fill_cnt_q == FW'(FILL - 1)) begin
                        state_q     <= S_RUN;
                        fill_done_q <= 1'b1;
                    end else begin
                        fill_cnt_q <= fill_cnt_q + FW'(1);
                    end
                end
                S_RUN: dec_cnt_q <= (dec_cnt_q == DW'(DECIM - 1)) ? '0 : dec_cnt_q + DW'(1);
                default: state_q <= S_FILL;
            endcase
        end
    end

    // Round half up in 33 bits so the bias add cannot wrap, then clamp to 16 bits.
    function automatic logic [15:0] narrow(input logic [31:0] x);
        logic signed [32:0] s;
        s = ($signed({x[31], x}) + RND) >>> SHIFT;
        if (s > 33'sd32767)
            return 16'h7fff;
        else if (s < -33'sd32768)
            return 16'h8000;
        else
            return s[15:0];
    endfunction

    logic sample_sel;
    assign sample_sel = (state_q == S_RUN) && in_en && (dec_cnt_q == DW'(DECIM - 1));

    logic [15:0]   mem_re [DEPTH];
    logic [15:0]   mem_im [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          pop, full, push, drop;

    assign pop  = (count_q != '0) && out_ready;
    assign full = (count_q == CW'(DEPTH));
    assign push = sample_sel && (!full || pop);
    assign drop = sample_sel && full && !pop;

    always_comb begin
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q | drop;
        if (push)
            wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)
            rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (!push && pop)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!rst && push) begin
            mem_re[wr_ptr_q] <= narrow(in_real);
            mem_im[wr_ptr_q] <= narrow(in_imag);
        end
    end

    assign out_valid = (count_q != '0);
    assign out_real  = out_valid ? mem_re[rd_ptr_q] : 16'h0000;
    assign out_imag  = out_valid ? mem_im[rd_ptr_q] : 16'h0000;
    assign fill_done = fill_done_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_lpf_decimator.sv
// tb/tb_lpf_decimator.sv - scoreboard bench for lpf_decimator with directed vectors
module tb_lpf_decimator;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        in_en = 1'b0;
    logic [31:0] in_real = '0;
    logic [31:0] in_imag = '0;
    logic [15:0] out_real, out_imag;
    logic        out_valid, out_ready = 1'b0;
    logic        fill_done, overflow;

    lpf_decimator dut (
        .clock(clock), .rst(rst), .in_en(in_en), .in_real(in_real), .in_imag(in_imag),
        .out_real(out_real), .out_imag(out_imag), .out_valid(out_valid),
        .out_ready(out_ready), .fill_done(fill_done), .overflow(overflow)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
        end
    endtask

    always @(negedge clock) begin
        if (!rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0)
                    chk("unexpected_valid", {31'b0, out_valid}, 32'd0);
                else begin
                    chk("out_pair", {out_real, out_imag}, exp_q[0]);
                    if (out_ready)
                        void'(exp_q.pop_front());
                end
            end else begin
                chk("empty_zero", {out_real, out_imag}, 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [31:0] r, input logic [31:0] i);
        in_en = 1'b1;
        in_real = r;
        in_imag = i;
        step();
        in_en = 1'b0;
    endtask

    // Seven discarded samples (with optional idle gap), then the selected one.
    task automatic group(input logic [31:0] r, input logic [31:0] i, input logic [31:0] e,
                         input bit push, input int gaps, input bit rdy_last);
        for (int k = 0; k < 7; k++) begin
            send($urandom, $urandom);
            if (k == 3)
                for (int g = 0; g < gaps; g++) step();
        end
        if (rdy_last)
            out_ready = 1'b1;
        if (push)
            exp_q.push_back(e);
        send(r, i);
    endtask

    task automatic fill();
        for (int k = 0; k < 30; k++)
            send(32'h0000_1000, 32'h0000_1000);
        chk("fill_done_before", {31'b0, fill_done}, 32'd0);
        send(32'h0000_1000, 32'h0000_1000);
        chk("fill_done_after", {31'b0, fill_done}, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_en = 1'b1;
        out_ready = 1'b1;
        in_real = 32'h7fff_ffff;
        in_imag = 32'h7fff_ffff;
        step();
        rst = 1'b0;
        in_en = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && exp_q.size() != 0; n++)
            @(posedge clock);
        chk("drain_complete", exp_q.size(), 32'd0);
        step();
        step();
        chk("drained_valid", {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        rst = 1'b0;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_pair", {out_real, out_imag}, 32'd0);
        chk("rst_fill_done", {31'b0, fill_done}, 32'd0);
        chk("rst_overflow", {31'b0, overflow}, 32'd0);

        fill();

        out_ready = 1'b1;
        group(32'h0000_1000, 32'h0000_0800, {16'd1, 16'd1}, 1, 0, 0);
        chk("latency_valid", {31'b0, out_valid}, 32'd1);
        step();
        chk("single_cycle_valid", {31'b0, out_valid}, 32'd0);

        group(32'h7fff_ffff, 32'h8000_0000, {16'h7fff, 16'h8000}, 1, 2, 0);
        group(32'hffff_f800, 32'hffff_f7ff, {16'h0000, 16'hffff}, 1, 0, 0);
        group(32'h0000_1800, 32'h0000_07ff, {16'h0002, 16'h0000}, 1, 1, 0);
        group(32'h07ff_f800, 32'hf7ff_f7ff, {16'h7fff, 16'h8000}, 1, 0, 0);
        drain();

        out_ready = 1'b0;
        for (int k = 1; k <= 8; k++)
            group(k << 12, -(k << 12), {16'(k), 16'(-k)}, 1, 0, 0);
        chk("full_no_overflow", {31'b0, overflow}, 32'd0);
        group(32'd99 << 12, 32'd99 << 12, 32'd0, 0, 0, 0);
        chk("overflow_set", {31'b0, overflow}, 32'd1);
        out_ready = 1'b1;
        drain();
        chk("overflow_sticky", {31'b0, overflow}, 32'd1);

        do_reset();
        chk("rst2_overflow", {31'b0, overflow}, 32'd0);
        fill();
        for (int k = 1; k <= 8; k++)
            group((k + 10) << 12, k << 12, {16'(k + 10), 16'(k)}, 1, 0, 0);
        group(32'd50 << 12, 32'd51 << 12, {16'd50, 16'd51}, 1, 0, 1);
        chk("full_pop_write_no_overflow", {31'b0, overflow}, 32'd0);
        drain();
        chk("full_pop_overflow_end", {31'b0, overflow}, 32'd0);

        for (int k = 1; k <= 3; k++)
            group(k << 12, k << 12, {16'(k), 16'(k)}, 1, 0, 0);
        chk("queued_valid", {31'b0, out_valid}, 32'd1);
        do_reset();
        chk("midrst_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_pair", {out_real, out_imag}, 32'd0);
        chk("midrst_fill_done", {31'b0, fill_done}, 32'd0);
        out_ready = 1'b1;
        fill();
        group(32'h0000_1000, 32'h0000_0800, {16'd1, 16'd1}, 1, 0, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
